// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of one single-port data memory
// between a processor port (A) and a host/loader port (B), plus a clear
// sequencer that zero-fills the whole memory while both requesters wait.
module data_mem_arbiter #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ReqA,
  input  logic         WeA,
  input  logic [A-1:0] AddrA,
  input  logic [W-1:0] WdataA,
  output logic         GntA,
  output logic [W-1:0] RdataA,
  output logic         RvalidA,
  input  logic         ReqB,
  input  logic         WeB,
  input  logic [A-1:0] AddrB,
  input  logic [W-1:0] WdataB,
  output logic         GntB,
  output logic [W-1:0] RdataB,
  output logic         RvalidB,
  input  logic         ClearStart,
  output logic         ClearBusy,
  output logic         ClearDone,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [A-1:0] LAST_ADDR = {A{1'b1}};
  localparam logic [A-1:0] ONE       = {{(A-1){1'b0}}, 1'b1};

  state_t       state;
  logic [A-1:0] clear_cnt;
  logic         last_b;
  logic         gnt_a;
  logic         gnt_b;
  logic [W-1:0] rdata_a;
  logic [W-1:0] rdata_b;
  logic         rvalid_a;
  logic         rvalid_b;
  logic         clear_done;

  // Grant decision: only in IDLE and never while reset is asserted; on
  // contention the port that was not served last wins.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == IDLE && !Reset) begin
      if (ReqA && ReqB) begin
        if (last_b) gnt_a = 1'b1;
        else        gnt_b = 1'b1;
      end else if (ReqA) begin
        gnt_a = 1'b1;
      end else if (ReqB) begin
        gnt_b = 1'b1;
      end
    end
  end

  // Memory port mux: clear writes take priority, otherwise the granted port.
  always_comb begin
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    if (state == CLEAR && !Reset) begin
      MemWriteEn = 1'b1;
      MemAddress = clear_cnt;
    end else if (gnt_a) begin
      MemWriteEn = WeA;
      MemAddress = AddrA;
      MemDataIn  = WdataA;
    end else if (gnt_b) begin
      MemWriteEn = WeB;
      MemAddress = AddrB;
      MemDataIn  = WdataB;
    end
  end

  // Controller state, clear sequencing, priority pointer and read-data return.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      clear_cnt  <= '0;
      last_b     <= 1'b1;
      rdata_a    <= '0;
      rdata_b    <= '0;
      rvalid_a   <= 1'b0;
      rvalid_b   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      rvalid_a   <= gnt_a && !WeA;
      rvalid_b   <= gnt_b && !WeB;
      clear_done <= 1'b0;
      if (gnt_a && !WeA) rdata_a <= MemDataOut;
      if (gnt_b && !WeB) rdata_b <= MemDataOut;
      if (gnt_a)      last_b <= 1'b0;
      else if (gnt_b) last_b <= 1'b1;
      case (state)
        IDLE: begin
          if (ClearStart) begin
            state     <= CLEAR;
            clear_cnt <= '0;
          end
        end
        CLEAR: begin
          clear_cnt <= clear_cnt + ONE;
          if (clear_cnt == LAST_ADDR) begin
            state      <= IDLE;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign GntA      = gnt_a;
  assign GntB      = gnt_b;
  assign RdataA    = rdata_a;
  assign RdataB    = rdata_b;
  assign RvalidA   = rvalid_a;
  assign RvalidB   = rvalid_b;
  assign ClearBusy = (state == CLEAR);
  assign ClearDone = clear_done;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level reference model and a shadow
// memory image.
module tb_data_mem_arbiter;

  localparam int W     = 8;
  localparam int A     = 8;
  localparam int DEPTH = 1 << A;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         ReqA, WeA, ReqB, WeB;
  logic [A-1:0] AddrA, AddrB;
  logic [W-1:0] WdataA, WdataB;
  logic         GntA, GntB, RvalidA, RvalidB;
  logic [W-1:0] RdataA, RdataB;
  logic         ClearStart, ClearBusy, ClearDone;
  logic         MemWriteEn;
  logic [A-1:0] MemAddress;
  logic [W-1:0] MemDataIn, MemDataOut;

  // Memory attached to the arbiter: combinational read, clocked write.
  logic [W-1:0] mem [DEPTH];
  logic         memInit;

  // Reference model state.
  logic [W-1:0] refMem [DEPTH];
  bit           clearing;
  int           clearIdx;
  bit           expLastB;
  bit           expRvA, expRvB, expDone;
  logic [W-1:0] expRdA, expRdB;

  logic obsGntA, obsGntB, obsBusy, obsDone;
  int   checks = 0;
  int   errors = 0;

  data_mem_arbiter #(.W(W), .A(A)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA(ReqA), .WeA(WeA), .AddrA(AddrA), .WdataA(WdataA),
    .GntA(GntA), .RdataA(RdataA), .RvalidA(RvalidA),
    .ReqB(ReqB), .WeB(WeB), .AddrB(AddrB), .WdataB(WdataB),
    .GntB(GntB), .RdataB(RdataB), .RvalidB(RvalidB),
    .ClearStart(ClearStart), .ClearBusy(ClearBusy), .ClearDone(ClearDone),
    .MemWriteEn(MemWriteEn), .MemAddress(MemAddress),
    .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Memory model behind the arbiter; zeroed while memInit is held.
  always @(posedge Clk) begin
    if (memInit) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (MemWriteEn) begin
      mem[MemAddress] <= MemDataIn;
    end
  end

  assign MemDataOut = mem[MemAddress];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [A-1:0] randAddr();
    if ($urandom_range(0, 3) == 0) return A'($urandom);
    return A'($urandom_range(0, 15));
  endfunction

  // One clock cycle: predict and check all outputs mid-cycle, then advance
  // the model with the inputs seen at the edge.
  task automatic applyStimulus(output bit gA, output bit gB);
    bit           eWe;
    logic [A-1:0] eAddr;
    logic [W-1:0] eData;
    @(negedge Clk);
    gA = 0;
    gB = 0;
    if (!Reset && !clearing) begin
      if (ReqA && ReqB) begin
        if (expLastB) gA = 1;
        else          gB = 1;
      end else begin
        gA = ReqA;
        gB = ReqB;
      end
    end
    eWe = 0;
    eAddr = '0;
    eData = '0;
    if (!Reset && clearing) begin
      eWe = 1;
      eAddr = clearIdx[A-1:0];
    end else if (gA) begin
      eWe = WeA; eAddr = AddrA; eData = WdataA;
    end else if (gB) begin
      eWe = WeB; eAddr = AddrB; eData = WdataB;
    end
    obsGntA = GntA;
    obsGntB = GntB;
    obsBusy = ClearBusy;
    obsDone = ClearDone;
    checkOutput("GntA", 32'(GntA), 32'(gA));
    checkOutput("GntB", 32'(GntB), 32'(gB));
    checkOutput("MemWriteEn", 32'(MemWriteEn), 32'(eWe));
    checkOutput("MemAddress", 32'(MemAddress), 32'(eAddr));
    checkOutput("MemDataIn", 32'(MemDataIn), 32'(eData));
    checkOutput("RvalidA", 32'(RvalidA), 32'(expRvA));
    checkOutput("RdataA", 32'(RdataA), 32'(expRdA));
    checkOutput("RvalidB", 32'(RvalidB), 32'(expRvB));
    checkOutput("RdataB", 32'(RdataB), 32'(expRdB));
    checkOutput("ClearBusy", 32'(ClearBusy), 32'(clearing));
    checkOutput("ClearDone", 32'(ClearDone), 32'(expDone));
    @(posedge Clk);
    if (Reset) begin
      clearing = 0; clearIdx = 0; expLastB = 1;
      expRvA = 0; expRvB = 0; expRdA = '0; expRdB = '0; expDone = 0;
    end else begin
      expDone = 0;
      expRvA = 0;
      expRvB = 0;
      if (clearing) begin
        refMem[clearIdx] = '0;
        clearIdx++;
        if (clearIdx == DEPTH) begin
          clearing = 0;
          clearIdx = 0;
          expDone = 1;
        end
      end else begin
        if (gA) begin
          if (WeA) refMem[AddrA] = WdataA;
          else begin expRdA = refMem[AddrA]; expRvA = 1; end
          expLastB = 0;
        end
        if (gB) begin
          if (WeB) refMem[AddrB] = WdataB;
          else begin expRdB = refMem[AddrB]; expRvB = 1; end
          expLastB = 1;
        end
        if (ClearStart) begin
          clearing = 1;
          clearIdx = 0;
        end
      end
    end
    #1;
  endtask

  task automatic accessA(input bit we, input logic [A-1:0] addr, input logic [W-1:0] data);
    bit gA, gB;
    bit done = 0;
    ReqA = 1; WeA = we; AddrA = addr; WdataA = data;
    for (int i = 0; i < 600 && !done; i++) begin
      applyStimulus(gA, gB);
      if (gA) done = 1;
    end
    ReqA = 0;
  endtask

  task automatic accessB(input bit we, input logic [A-1:0] addr, input logic [W-1:0] data);
    bit gA, gB;
    bit done = 0;
    ReqB = 1; WeB = we; AddrB = addr; WdataB = data;
    for (int i = 0; i < 600 && !done; i++) begin
      applyStimulus(gA, gB);
      if (gB) done = 1;
    end
    ReqB = 0;
  endtask

  // Scenario sequencing.
  initial begin
    bit       gA, gB, pA, pB;
    bit [3:0] seq;
    int       busyCnt, doneCnt, bGntK, doneK;

    Reset = 1; memInit = 1;
    ReqA = 0; WeA = 0; AddrA = '0; WdataA = '0;
    ReqB = 0; WeB = 0; AddrB = '0; WdataB = '0;
    ClearStart = 0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    clearing = 0; clearIdx = 0; expLastB = 1;
    expRvA = 0; expRvB = 0; expRdA = '0; expRdB = '0; expDone = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 0;
    memInit = 0;

    $display("[TB] reset values");
    checkOutput("rst_GntA", 32'(GntA), 0);
    checkOutput("rst_GntB", 32'(GntB), 0);
    checkOutput("rst_RdataA", 32'(RdataA), 0);
    checkOutput("rst_RvalidA", 32'(RvalidA), 0);
    checkOutput("rst_ClearBusy", 32'(ClearBusy), 0);
    checkOutput("rst_ClearDone", 32'(ClearDone), 0);
    checkOutput("rst_MemWriteEn", 32'(MemWriteEn), 0);
    checkOutput("rst_MemAddress", 32'(MemAddress), 0);

    $display("[TB] write then read on port A");
    accessA(1, 8'h10, 8'hAB);
    accessA(0, 8'h10, 8'h00);
    checkOutput("t1_RvalidA", 32'(RvalidA), 1);
    checkOutput("t1_RdataA", 32'(RdataA), 32'hAB);
    checkOutput("t1_RdataB", 32'(RdataB), 0);
    applyStimulus(gA, gB);

    $display("[TB] contention");
    accessB(1, 8'h02, 8'h22);
    ReqA = 1; WeA = 0; AddrA = 8'h01;
    ReqB = 1; WeB = 0; AddrB = 8'h02;
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(gA, gB);
      seq = {seq[2:0], obsGntA};
    end
    checkOutput("rr_sequence", 32'(seq), 32'b1010);
    ReqA = 0; ReqB = 0;
    applyStimulus(gA, gB);
    checkOutput("rr_RdataB", 32'(RdataB), 32'h22);

    $display("[TB] full clear");
    accessA(1, 8'h00, 8'h55);
    accessA(1, 8'hFF, 8'h55);
    ClearStart = 1;
    applyStimulus(gA, gB);
    ClearStart = 0;
    busyCnt = 0; doneCnt = 0; bGntK = -1; doneK = -1;
    for (int k = 0; k < 300; k++) begin
      if (k == 30) begin ReqB = 1; WeB = 0; AddrB = 8'h05; end
      ClearStart = (k == 100);
      applyStimulus(gA, gB);
      if (gB) ReqB = 0;
      if (obsBusy) busyCnt++;
      if (obsDone) begin doneCnt++; if (doneK < 0) doneK = k; end
      if (obsGntB && bGntK < 0) bGntK = k;
    end
    ClearStart = 0;
    checkOutput("clr_busy_cycles", 32'(busyCnt), 256);
    checkOutput("clr_done_count", 32'(doneCnt), 1);
    checkOutput("clr_done_cycle", 32'(doneK), 256);
    checkOutput("clr_b_gnt_cycle", 32'(bGntK), 256);
    accessA(0, 8'h00, 8'h00);
    checkOutput("clr_read00", 32'(RdataA), 0);
    accessA(0, 8'hFF, 8'h00);
    checkOutput("clr_readFF", 32'(RdataA), 0);

    $display("[TB] reset during clear");
    accessA(1, 8'h80, 8'h3C);
    ClearStart = 1;
    applyStimulus(gA, gB);
    ClearStart = 0;
    repeat (50) applyStimulus(gA, gB);
    Reset = 1;
    applyStimulus(gA, gB);
    Reset = 0;
    doneCnt = 0;
    applyStimulus(gA, gB);
    checkOutput("rstclr_busy", 32'(obsBusy), 0);
    if (obsDone) doneCnt++;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(gA, gB);
      if (obsDone) doneCnt++;
    end
    checkOutput("rstclr_no_done", 32'(doneCnt), 0);
    accessA(0, 8'h80, 8'h00);
    checkOutput("rstclr_keep80", 32'(RdataA), 32'h3C);

    $display("[TB] random traffic");
    pA = 0; pB = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!pA && $urandom_range(0, 2) == 0) begin
        pA = 1; WeA = 1'($urandom_range(0, 1)); AddrA = randAddr(); WdataA = W'($urandom);
      end
      if (!pB && $urandom_range(0, 2) == 0) begin
        pB = 1; WeB = 1'($urandom_range(0, 1)); AddrB = randAddr(); WdataB = W'($urandom);
      end
      ReqA = pA;
      ReqB = pB;
      ClearStart = ($urandom_range(0, 399) == 0);
      applyStimulus(gA, gB);
      if (gA) pA = 0;
      if (gB) pB = 0;
    end
    ReqA = 0; ReqB = 0; ClearStart = 0;
    applyStimulus(gA, gB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory (one address pointer, combinational read, clocked write) between two requesters: port A (processor load/store path) and port B (host/debug or loader). Arbitration is round-robin with a req/gnt handshake and registered read-data return. It also contains a clear sequencer that zero-fills the whole memory on command while stalling both requesters. It sits directly between the requesters and the memory, and is the only block that drives the memory's write-enable, address and write-data inputs.

## Interface
- W, 8, data width
- A, 8, address width; memory depth 2**A
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- ReqA / ReqB  in  1  access request; held high with Addr/We/Wdata stable until the matching Gnt is seen
- WeA / WeB  in  1  1 = write, 0 = read
- AddrA / AddrB  in  A  access address
- WdataA / WdataB  in  W  write data
- GntA / GntB  out  1  combinational; transaction is performed in the cycle Gnt is high
- RdataA / RdataB  out  W  registered read data
- RvalidA / RvalidB  out  1  one-cycle pulse, Rdata valid
- ClearStart  in  1  pulse; requests a zero-fill of the whole memory
- ClearBusy  out  1  high while clearing
- ClearDone  out  1  one-cycle pulse after the last clear write
- MemWriteEn  out  1  memory write enable
- MemAddress  out  A  memory address
- MemDataIn  out  W  memory write data
- MemDataOut  in  W  memory read data (combinational from MemAddress)

## Operation
- States: IDLE, CLEAR. Reset forces IDLE, clear counter = 0, and priority pointer = "A first" (LastGnt = B).
- IDLE arbitration:
  - Only ReqA: GntA = 1.
  - Only ReqB: GntB = 1.
  - Both requesting: grant the port that is not LastGnt.
  - At most one Gnt per cycle.
  - LastGnt updates at the edge ending any granted cycle.
- Granted cycle drives MemAddress = Addr, MemWriteEn = We, MemDataIn = Wdata of the granted port.
- Granted read: MemDataOut is captured into that port's Rdata at the edge; its Rvalid is high the next cycle.
- Granted write: no Rvalid. The memory is updated at the same edge.
- No grant in IDLE: MemWriteEn = 0, MemAddress = 0, MemDataIn = 0.
- ClearStart in IDLE:
  - Arbitration still operates normally in that cycle.
  - Transition to CLEAR at the edge.
- CLEAR:
  - Drives MemWriteEn = 1, MemAddress = counter, MemDataIn = 0.
  - GntA = GntB = 0. Requests wait, not dropped.
  - Counter increments each cycle.
  - When counter = 2**A-1 the write completes; next state is IDLE, counter wraps to 0, ClearDone pulses in the first IDLE cycle.
- ClearStart while in CLEAR is ignored (no restart, no extension).
- Rdata holds its last captured value until the next read grant to that port.

## Timing
- Reset values: GntA/B = 0, RdataA/B = 0, RvalidA/B = 0, ClearBusy = 0, ClearDone = 0, MemWriteEn = 0, MemAddress = 0, MemDataIn = 0.
- Grant latency: 0 cycles (same cycle as Req) when uncontended in IDLE.
- Read latency: Rvalid one cycle after Gnt.
- Back-to-back grants to the same port are allowed when the other port is idle.
- Under continuous contention, grants alternate A, B, A, B.
- Clear duration: exactly 2**A cycles of ClearBusy = 1 (256 at default). ClearDone follows in the next cycle.
- Reset during CLEAR:
  - Next cycle is IDLE with ClearBusy = 0.
  - No ClearDone.
  - Partially cleared contents are not restored.
- Reset during a read grant: the pending Rvalid is suppressed (forced to 0).
- Read and write to the same address by A and B in one cycle cannot occur (single grant). Ordering follows grant order.

## Test plan
- Reset, then ReqA write addr 0x10 = 0xAB -> GntA same cycle, MemWriteEn = 1. Then ReqA read 0x10 -> RvalidA next cycle, RdataA = 0xAB; RdataB unchanged 0.
- ReqA and ReqB both held for 4 cycles (reads of 0x01/0x02) -> grant sequence A, B, A, B; each Rvalid appears only on its own port, one cycle after its grant.
- Preload addr 0x00 and 0xFF with 0x55; pulse ClearStart -> ClearBusy high 256 cycles, MemAddress 0x00..0xFF, ClearDone pulse next. Reads of 0x00 and 0xFF then return 0x00.
- ReqB raised mid-CLEAR -> GntB stays 0 until the first IDLE cycle, then GntB = 1 and the access completes.
- ClearStart re-pulsed at clear cycle 100 -> no effect; total busy still 256 cycles.
- Reset at clear cycle 50 -> next cycle ClearBusy = 0, no ClearDone, all outputs at reset values; addr 0x80 retains its preloaded value.
